// File: rtl/bcd_display_driver.sv
// bcd_display_driver: 8-bit binary -> 3-digit BCD (sequential double-dabble)
// driving a time-multiplexed 3-digit 7-segment display.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   data_in     in   [7:0] unsigned value to convert
//   data_valid  in   strobe: sample data_in this edge
//   busy        out  conversion in progress (SHIFT state)
//   bcd_valid   out  one-cycle pulse, bcd_out just updated
//   bcd_out     out  [11:0] {hundreds,tens,units} of last conversion
//   seg         out  [6:0] {g,f,e,d,c,b,a} for the active digit
//   an          out  [2:0] digit enables, [0]=units .. [2]=hundreds
module bcd_display_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        busy,
  output logic        bcd_valid,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_shift;
  logic [11:0] r_scr;
  logic [2:0]  r_iter;
  logic        r_pend_v;
  logic [7:0]  r_pend;
  logic [11:0] r_bcd;
  logic        r_valid;
  logic [CW-1:0] r_refresh;
  logic [1:0]  r_digit;

  logic [11:0] w_adj;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg_hi;
  logic [2:0]  w_an_hi;

  // add-3 correction applied to every BCD nibble before the shift
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < 3; i++) begin
      if (r_scr[i*4 +: 4] >= 4'd5)
        w_adj[i*4 +: 4] = r_scr[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (data_valid || r_pend_v) w_next = S_SHIFT;
      S_SHIFT: if (r_iter == 3'd7) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift  <= '0;
      r_scr    <= '0;
      r_iter   <= '0;
      r_pend_v <= 1'b0;
      r_pend   <= '0;
      r_bcd    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // a fresh strobe beats (and discards) a pending value
          if (data_valid) begin
            r_shift  <= data_in;
            r_scr    <= '0;
            r_iter   <= '0;
            r_pend_v <= 1'b0;
          end else if (r_pend_v) begin
            r_shift  <= r_pend;
            r_scr    <= '0;
            r_iter   <= '0;
            r_pend_v <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_scr   <= {w_adj[10:0], r_shift[7]};
          r_shift <= {r_shift[6:0], 1'b0};
          r_iter  <= r_iter + 3'd1;
        end
        S_DONE: begin
          r_bcd   <= r_scr;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
      // newest strobe while busy/done wins the one-deep slot
      if (data_valid && r_state != S_IDLE) begin
        r_pend   <= data_in;
        r_pend_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh <= '0;
      r_digit   <= '0;
    end else if (r_refresh == CW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_digit   <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  always_comb begin
    case (r_digit)
      2'd0:    w_nib = r_bcd[3:0];
      2'd1:    w_nib = r_bcd[7:4];
      default: w_nib = r_bcd[11:8];
    endcase
  end

  always_comb begin
    w_blank = 1'b0;
    if (BLANK_LEADING) begin
      if (r_digit == 2'd2 && r_bcd[11:8] == 4'd0)
        w_blank = 1'b1;
      if (r_digit == 2'd1 && r_bcd[11:4] == 8'd0)
        w_blank = 1'b1;
    end
  end

  always_comb begin
    case (w_nib)
      4'd0:    w_seg_hi = 7'b0111111;
      4'd1:    w_seg_hi = 7'b0000110;
      4'd2:    w_seg_hi = 7'b1011011;
      4'd3:    w_seg_hi = 7'b1001111;
      4'd4:    w_seg_hi = 7'b1100110;
      4'd5:    w_seg_hi = 7'b1101101;
      4'd6:    w_seg_hi = 7'b1111101;
      4'd7:    w_seg_hi = 7'b0000111;
      4'd8:    w_seg_hi = 7'b1111111;
      4'd9:    w_seg_hi = 7'b1101111;
      default: w_seg_hi = 7'b0000000;
    endcase
    if (w_blank) w_seg_hi = 7'b0000000;
  end

  always_comb begin
    case (r_digit)
      2'd0:    w_an_hi = 3'b001;
      2'd1:    w_an_hi = 3'b010;
      default: w_an_hi = 3'b100;
    endcase
  end

  assign seg       = SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
  assign an        = SEG_ACTIVE_LOW ? ~w_an_hi : w_an_hi;
  assign busy      = (r_state == S_SHIFT);
  assign bcd_valid = r_valid;
  assign bcd_out   = r_bcd;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver (REFRESH_DIV=4), scoreboard of
// expected {value, valid-cycle} pairs checked when bcd_valid pulses.
module tb_bcd_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        busy;
  logic        bcd_valid;
  logic [11:0] bcd_out;
  logic [6:0]  seg;
  logic [2:0]  an;

  typedef struct {
    logic [11:0] v;
    int          c;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  int   cyc = 0;

  bcd_display_driver #(
    .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b1),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_valid(data_valid),
    .busy(busy),
    .bcd_valid(bcd_valid),
    .bcd_out(bcd_out),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] v, output int n);
    @(negedge clk);
    data_in    = v;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    n = cyc;
  endtask

  task automatic push(input logic [11:0] v, input int c);
    exp_t e;
    e.v = v;
    e.c = c;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bcd_valid === 1'b1) begin
      exp_t e;
      n_valid++;
      chk("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("bcd_out", {20'd0, bcd_out}, {20'd0, e.v});
        chk("valid_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, m, nb, nv, prev;
    bit found;
    logic [2:0] ean [3];
    logic [6:0] eseg [3];

    reset      = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
    chk("rst_bcd", {20'd0, bcd_out}, 32'd0);
    chk("rst_an", {29'd0, an}, 32'b110);
    chk("rst_seg", {25'd0, seg}, 32'b1000000);
    reset = 1'b0;
    idle(2);

    // zero, nine-edge latency
    strobe(8'd0, n);
    push(12'h000, n + 9);
    idle(12);

    // max value, busy exactly 8 cycles
    nv = n_valid;
    strobe(8'd255, n);
    push(12'h255, n + 9);
    nb = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
    end
    chk("busy_cycles", nb, 8);
    idle(2);
    chk("bcd_255", {20'd0, bcd_out}, 32'h255);
    chk("pulses_255", n_valid - nv, 1);

    // display scan of 7
    strobe(8'd7, n);
    push(12'h007, n + 9);
    idle(12);
    ean[0] = 3'b110;
    ean[1] = 3'b101;
    ean[2] = 3'b011;
    eseg[0] = 7'b1111000;
    eseg[1] = 7'b1111111;
    eseg[2] = 7'b1111111;
    found = 1'b0;
    @(negedge clk);
    prev = int'(an);
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (an == 3'b110 && prev != 3'b110) found = 1'b1;
      prev = int'(an);
    end
    chk("scan_sync", {31'd0, found}, 32'd1);
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (s != 0 || k != 0) @(negedge clk);
        chk($sformatf("scan_an_%0d_%0d", s, k), {29'd0, an},
            {29'd0, ean[s]});
        chk($sformatf("scan_seg_%0d_%0d", s, k), {25'd0, seg},
            {25'd0, eseg[s]});
      end
    end
    @(negedge clk);
    chk("scan_wrap", {29'd0, an}, 32'b110);

    // pending: newest wins, 42 never appears
    nv = n_valid;
    strobe(8'd100, n);
    push(12'h100, n + 9);
    strobe(8'd42, m);
    idle(1);
    strobe(8'd43, m);
    push(12'h043, n + 19);
    idle(25);
    chk("pulses_pend", n_valid - nv, 2);
    chk("bcd_43", {20'd0, bcd_out}, 32'h043);

    // reset during 4th shift cycle aborts conversion
    nv = n_valid;
    strobe(8'd200, n);
    idle(3);
    chk("busy_pre_rst", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_bcd", {20'd0, bcd_out}, 32'd0);
    chk("mid_rst_an", {29'd0, an}, 32'b110);
    chk("mid_rst_seg", {25'd0, seg}, 32'b1000000);
    @(negedge clk);
    reset = 1'b0;
    idle(15);
    chk("pulses_after_rst", n_valid - nv, 0);
    chk("busy_after_rst", {31'd0, busy}, 32'd0);

    // re-strobe in the bcd_valid cycle
    nv = n_valid;
    strobe(8'd128, n);
    push(12'h128, n + 9);
    idle(9);
    chk("valid_at_restrobe", {31'd0, bcd_valid}, 32'd1);
    strobe(8'd9, m);
    chk("restrobe_edge", m, n + 10);
    push(12'h009, m + 9);
    idle(15);
    chk("pulses_restart", n_valid - nv, 2);
    chk("bcd_9", {20'd0, bcd_out}, 32'h009);

    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
